// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity link (transmitter and receiver).
package serial_parity_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity
  } rx_state_t;

  localparam logic StartBit = 1'b0;

endpackage

// File: rtl/serial_to_parallel_parity_rx_parity_accum.sv
// Running XOR parity register with synchronous clear and bit-enable.
module parity_accum (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic parity_o
);

  logic parity_d, parity_q;

  always_comb begin
    parity_d = parity_q;
    if (clr_i) begin
      parity_d = 1'b0;
    end else if (en_i) begin
      parity_d = parity_q ^ bit_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_o = parity_q;

endmodule

// File: rtl/serial_to_parallel_parity_rx.sv
// Serial parity link receiver: start bit, Width data bits, parity bit -> word plus error flag.
module serial_to_parallel_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int unsigned Width     = 8,
  parameter bit          ParityOdd = 1'b0,
  parameter bit          MsbFirst  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             serial_valid_i,
  input  logic             serial_data_i,
  output logic             parallel_valid_o,
  output logic [Width-1:0] parallel_data_o,
  output logic             parity_error_o,
  output logic             busy_o
);

  localparam int unsigned       CntW   = $clog2(Width);
  localparam logic [CntW-1:0]   CntMax = CntW'(Width - 1);

  rx_state_t        state_q;
  logic [CntW-1:0]  cnt_q;
  logic [CntW-1:0]  bit_idx;
  logic [Width-1:0] shift_q;
  logic [Width-1:0] pdata_q;
  logic             pvalid_q;
  logic             perr_q;
  logic             parity_q;
  logic             parity_clr;
  logic             parity_en;

  always_comb begin
    bit_idx = cnt_q;
    if (MsbFirst) begin
      bit_idx = CntMax - cnt_q;
    end
  end

  // Parity restarts on the start bit and accumulates only over data bits.
  assign parity_clr = serial_valid_i && (state_q == StIdle) && (serial_data_i == StartBit);
  assign parity_en  = serial_valid_i && (state_q == StData);

  parity_accum u_parity_accum (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (parity_clr),
    .en_i     (parity_en),
    .bit_i    (serial_data_i),
    .parity_o (parity_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      pdata_q  <= '0;
      pvalid_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      pvalid_q <= 1'b0;
      if (serial_valid_i) begin
        unique case (state_q)
          StIdle: begin
            if (serial_data_i == StartBit) begin
              state_q <= StData;
              cnt_q   <= '0;
            end
          end
          StData: begin
            shift_q[bit_idx] <= serial_data_i;
            cnt_q            <= cnt_q + 1'b1;
            if (cnt_q == CntMax) begin
              state_q <= StParity;
            end
          end
          StParity: begin
            state_q  <= StIdle;
            pdata_q  <= shift_q;
            perr_q   <= parity_q ^ serial_data_i ^ ParityOdd;
            pvalid_q <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign parallel_valid_o = pvalid_q;
  assign parallel_data_o  = pdata_q;
  assign parity_error_o   = perr_q;
  assign busy_o           = (state_q != StIdle);

endmodule
